// File: rtl/uart_fifo_pkg.sv
// Shared FIFO pointer helpers: default address width and Gray/binary conversion.
// Used by the UART FIFO controller and the async FIFO.
package uart_fifo_pkg;

  localparam int AW_DEF = 4;
  localparam int PW     = AW_DEF + 1;

  // Operate on 32-bit zero-extended values so any pointer width up to 32 can share them.
  function automatic logic [31:0] to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] to_bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/uart_fifo_ptr_ctrl_if.sv
// Requester/RAM-side bundle of the UART FIFO pointer controller.
// level/almost_full exist only when UART_FIFO_LEVEL_EN is defined.
interface uart_fifo_ptr_ctrl_if
  import uart_fifo_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic          wr_req;
  logic          rd_req;
  logic          err_clr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
`ifdef UART_FIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  modport master (
    output wr_req, rd_req, err_clr,
    input  mem_we, mem_waddr, mem_re, mem_raddr, rd_valid,
           full, empty, overflow, underflow
`ifdef UART_FIFO_LEVEL_EN
    , input level, almost_full
`endif
  );

  modport slave (
    input  wr_req, rd_req, err_clr,
    output mem_we, mem_waddr, mem_re, mem_raddr, rd_valid,
           full, empty, overflow, underflow
`ifdef UART_FIFO_LEVEL_EN
    , output level, almost_full
`endif
  );

endinterface

// File: rtl/uart_gray_ptr.sv
// One FIFO pointer held in Gray form; exposes current/next Gray value and the RAM address.
module uart_gray_ptr
  import uart_fifo_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW:0]   gray,
  output logic [AW:0]   gray_next,
  output logic [AW-1:0] addr
);
  typedef logic [AW:0] ptr_t;

  ptr_t gray_q;
  ptr_t bin;
  ptr_t bin_next;

  assign bin       = ptr_t'(to_bin(32'(gray_q)));
  assign bin_next  = inc ? bin + 1'b1 : bin;
  assign gray_next = ptr_t'(to_gray(32'(bin_next)));
  assign gray      = gray_q;
  assign addr      = bin[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) gray_q <= '0;
    else     gray_q <= gray_next;
  end

endmodule

// File: rtl/uart_fifo_ptr_ctrl.sv
// Single-clock UART FIFO pointer controller: push/pop arbitration, RAM address/enables, status.
// Optional occupancy outputs (level, almost_full) are built when UART_FIFO_LEVEL_EN is defined.
module uart_fifo_ptr_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int AW = AW_DEF
`ifdef UART_FIFO_LEVEL_EN
  , parameter int AF_MARGIN = 2
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_fifo_ptr_ctrl_if.slave  bus
);
  typedef logic [AW:0] ptr_t;

  ptr_t wg, wg_n, rg, rg_n;
  logic push_ok, pop_ok;
  logic empty_q, full_q, rd_valid_q, ovf_q, udf_q;
  logic empty_n, full_n;

  // Accept decisions use the registered flags, so push/pop at full/empty resolve naturally.
  assign push_ok = bus.wr_req & ~full_q;
  assign pop_ok  = bus.rd_req & ~empty_q;

  uart_gray_ptr #(.AW(AW)) u_wptr (
    .clk       (clk),
    .rst       (rst),
    .inc       (push_ok),
    .gray      (wg),
    .gray_next (wg_n),
    .addr      (bus.mem_waddr)
  );

  uart_gray_ptr #(.AW(AW)) u_rptr (
    .clk       (clk),
    .rst       (rst),
    .inc       (pop_ok),
    .gray      (rg),
    .gray_next (rg_n),
    .addr      (bus.mem_raddr)
  );

  // Full in Gray: top two bits inverted, remaining bits equal.
  assign empty_n = (wg_n == rg_n);
  assign full_n  = (wg_n == {~rg_n[AW:AW-1], rg_n[AW-2:0]});

  always_ff @(posedge clk) begin
    if (rst) begin
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      empty_q    <= empty_n;
      full_q     <= full_n;
      rd_valid_q <= pop_ok;
      ovf_q      <= (ovf_q & ~bus.err_clr) | (bus.wr_req & full_q);
      udf_q      <= (udf_q & ~bus.err_clr) | (bus.rd_req & empty_q);
    end
  end

  assign bus.mem_we    = push_ok;
  assign bus.mem_re    = pop_ok;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

`ifdef UART_FIFO_LEVEL_EN
  ptr_t level_n, level_q;
  logic af_n, af_q;

  assign level_n = ptr_t'(to_bin(32'(wg_n))) - ptr_t'(to_bin(32'(rg_n)));
  assign af_n    = ((2 ** AW) - int'(level_n)) <= AF_MARGIN;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_n;
      af_q    <= af_n;
    end
  end

  assign bus.level       = level_q;
  assign bus.almost_full = af_q;
`endif

endmodule
